// File: rtl/uart_tx.sv
// UART transmit engine: start bit, BusWidth data bits LSB first, optional parity, one stop bit.
// One frame bit per CLK period; TX_OUT and BUSY come straight from flops.
module uart_tx #(
  parameter int BusWidth = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [BusWidth-1:0] P_DATA,
  input  logic                DATA_VALID,
  input  logic                PAR_EN,
  input  logic                PAR_TYP,
  output logic                TX_OUT,
  output logic                BUSY,
  output logic [2:0]          state_dbg
);

  localparam int CW = $clog2(BusWidth);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [BusWidth-1:0] shift_q;
  logic                par_en_q;
  logic                par_bit_q;
  logic                accept;

  // Handshake: DATA_VALID is taken at a rising edge only while the engine is
  // not busy (IDLE or STOP); otherwise the strobe is dropped without trace.
  assign accept    = DATA_VALID && ((state == IDLE) || (state == STOP));
  assign state_dbg = state;

  // Outputs are registered alongside the next state, so each cycle's
  // TX_OUT/BUSY already reflect the bit that state is transmitting.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      BUSY      <= 1'b0;
      cnt       <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      case (state)
        IDLE, STOP: begin
          if (accept) begin
            shift_q   <= P_DATA;
            par_en_q  <= PAR_EN;
            par_bit_q <= PAR_TYP ? ~^P_DATA : ^P_DATA;
            state     <= START;
            TX_OUT    <= 1'b0;
            BUSY      <= 1'b1;
          end else begin
            state  <= IDLE;
            TX_OUT <= 1'b1;
            BUSY   <= 1'b0;
          end
        end
        START: begin
          state   <= DATA;
          cnt     <= '0;
          TX_OUT  <= shift_q[0];
          shift_q <= shift_q >> 1;
          BUSY    <= 1'b1;
        end
        DATA: begin
          // cnt names the bit currently on the line; the shifter already holds the next one.
          if (cnt == CW'(BusWidth - 1)) begin
            if (par_en_q) begin
              state  <= PARITY;
              TX_OUT <= par_bit_q;
              BUSY   <= 1'b1;
            end else begin
              state  <= STOP;
              TX_OUT <= 1'b1;
              BUSY   <= 1'b0;
            end
          end else begin
            cnt     <= cnt + CW'(1);
            TX_OUT  <= shift_q[0];
            shift_q <= shift_q >> 1;
            BUSY    <= 1'b1;
          end
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmit engine for the UART: accepts a parallel word with a one-cycle valid strobe and shifts out one asynchronous frame. The frame is a start bit, BusWidth data bits LSB first, an optional even/odd parity bit, and one stop bit. It runs on the baud-rate clock, so each frame bit lasts exactly one CLK period. It is the transmit-side counterpart of the receiver's parity checker and uses the same PAR_TYP encoding, so a uart_tx/RX loopback yields PAR_ERR = 0.

## Interface
- BusWidth, 8, data word width in bits (≥ 2)
- CLK  input  1  baud-rate clock, all state on rising edge
- RST  input  1  asynchronous, active-low reset
- P_DATA  input  BusWidth  parallel word to send, sampled on the accepting edge only
- DATA_VALID  input  1  request strobe, accepted when BUSY = 0 at the rising edge
- PAR_EN  input  1  1 = insert parity bit, sampled on the accepting edge
- PAR_TYP  input  1  0 = even, 1 = odd, sampled on the accepting edge
- TX_OUT  output  1  serial line, registered, idles high
- BUSY  output  1  registered, 1 = a new request will be ignored

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Reset values: state IDLE, TX_OUT = 1, BUSY = 0, bit counter 0, shift/config registers 0.
- Accept condition: DATA_VALID = 1 and state ∈ {IDLE, STOP}.
- On accept, the block latches P_DATA, PAR_EN and PAR_TYP, and computes the parity bit.
  - Even parity: parity bit = ^P_DATA.
  - Odd parity: parity bit = ~^P_DATA.
- Input changes after the accepting edge have no effect on the frame in flight.
- IDLE: TX_OUT = 1, BUSY = 0. On accept, go to START.
- START: TX_OUT = 0, BUSY = 1. Then go to DATA with the counter at 0.
- DATA: TX_OUT = latched_data[counter], BUSY = 1.
  - The counter increments each cycle.
  - After bit BusWidth-1, go to PARITY if the latched PAR_EN = 1, else STOP.
- PARITY: TX_OUT = latched parity bit, BUSY = 1. Then go to STOP.
- STOP: TX_OUT = 1, BUSY = 0.
  - On accept, go directly to START. This gives back-to-back frames with no idle gap.
  - Otherwise go to IDLE.
- DATA_VALID while BUSY = 1 is dropped silently. There is no queue and no error flag.
- Bit counter width is $clog2(BusWidth). It never wraps past BusWidth-1.
- TX_OUT and BUSY are driven from flops, not decoded combinationally from the state.

## Timing
- Edge T0 accepts a request. TX_OUT = 0 (start) and BUSY = 1 during cycle T0+1.
- Data bit i appears during cycle T0+2+i.
- Parity bit, if enabled, appears during T0+2+BusWidth.
- Stop bit appears during T0+2+BusWidth+PAR_EN. BUSY = 0 in the stop cycle.
- Frame length is 2 + BusWidth + PAR_EN cycles.
  - BusWidth = 8: 10 cycles without parity, 11 with parity.
- Back-to-back: DATA_VALID held high continuously gives one frame per frame period. The next start bit immediately follows the stop bit.
- Minimum DATA_VALID width is one cycle. A strobe held over several cycles during BUSY = 1 is accepted only at the first non-busy edge (STOP or IDLE).
- Reset mid-frame: TX_OUT goes to 1 and BUSY to 0 immediately (asynchronous). The frame is abandoned.
- After reset release, the first accept is possible at the first rising edge.

## Test plan
- Reset, then idle 5 cycles → TX_OUT = 1, BUSY = 0 throughout.
- P_DATA = 0xA5, PAR_EN = 0, one-cycle strobe → TX_OUT sequence 0,1,0,1,0,0,1,0,1,1. BUSY high for cycles T0+1..T0+9 and low in the stop cycle.
- P_DATA = 0xA5 (four ones), PAR_EN = 1:
  - PAR_TYP = 0 → parity bit 0.
  - PAR_TYP = 1 → parity bit 1.
  - Both give an 11-cycle frame.
- DATA_VALID held high with 0x01, then 0xFF switched in at the stop cycle, PAR_EN = 0 → two contiguous 10-cycle frames with no idle bit. The second frame carries 0xFF.
- Strobe 0x3C mid-frame while BUSY = 1, and toggle PAR_TYP/P_DATA mid-frame → current frame unchanged and the 0x3C request is dropped.
- Assert RST low during data bit 3 → TX_OUT = 1 and BUSY = 0 without a clock edge. The next accepted word (0x5A) transmits as a clean full frame.
